// File: rtl/rng_addr_gen.sv
// RNG consumer: filters 19-bit indices against a line region, scales them to byte addresses and
// issues them as a single-slot request stream. Define RNG_ADDR_GEN_STATS_EN for skipped/stalls counters.
module rng_addr_gen #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned LINE_LOG2 = 6,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [19:0]       cfg_num_lines,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              rng_ready,
  input  logic [18:0]       rng_data,
  output logic              rng_next,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              busy,
  output logic              done,
`ifdef RNG_ADDR_GEN_STATS_EN
  output logic [CNT_W-1:0]  skipped,
  output logic [CNT_W-1:0]  stalls,
`endif
  output logic [CNT_W-1:0]  issued
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [19:0]       lines_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  loaded;
  logic [ADDR_W-1:0] idx_ext;
  logic [ADDR_W-1:0] line_off;
  logic              start_ok, cfg_empty, pop, accept, hs, hs_last;

  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  assign cfg_empty = (count_q == '0) || (lines_q == '0);

  // Empty regions never pull, so a zero-size run finishes without touching the RNG.
  assign rng_next = (state == S_RUN) && rng_ready && !cfg_empty && (loaded < count_q)
                    && (!req_valid || req_ready);
  assign pop      = rng_next;
  assign accept   = pop && ({1'b0, rng_data} < lines_q);
  assign hs       = req_valid && req_ready;
  assign hs_last  = hs && ((issued + ONE) == count_q);

  assign idx_ext  = {{(ADDR_W-19){1'b0}}, rng_data};
  assign line_off = idx_ext << LINE_LOG2;

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      // The final handshake can land while still in RUN when the last index fills the slot.
      S_RUN: begin
        if (cfg_empty || hs_last)  state_nxt = S_DONE;
        else if (loaded == count_q) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (hs_last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
      req_addr  <= '0;
      issued    <= '0;
      loaded    <= '0;
      base_q    <= '0;
      lines_q   <= '0;
      count_q   <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        base_q  <= cfg_base;
        lines_q <= cfg_num_lines;
        count_q <= cfg_count;
        issued  <= '0;
        loaded  <= '0;
      end else begin
        if (hs) issued <= issued + ONE;
        if (accept) begin
          req_valid <= 1'b1;
          req_addr  <= base_q + line_off;
          loaded    <= loaded + ONE;
        end else if (hs) begin
          req_valid <= 1'b0;
        end
      end
    end
  end

`ifdef RNG_ADDR_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      skipped <= '0;
      stalls  <= '0;
    end else begin
      if (pop && !accept) skipped <= skipped + ONE;
      if (busy && req_valid && !req_ready) stalls <= stalls + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_rng_addr_gen.sv
// Randomized bench for rng_addr_gen: a transaction-level model predicts the request stream
// from the indices the DUT consumes; directed runs cover ordering, filtering, stalls, empty config, reset and wrap.
module tb_rng_addr_gen;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned LINE_LOG2 = 6;
  localparam int unsigned CNT_W     = 32;

  logic              clk, rst_n, start;
  logic [ADDR_W-1:0] cfg_base;
  logic [19:0]       cfg_num_lines;
  logic [CNT_W-1:0]  cfg_count;
  logic              rng_ready, rng_next;
  logic [18:0]       rng_data;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              busy, done;
  logic [CNT_W-1:0]  issued;
`ifdef RNG_ADDR_GEN_STATS_EN
  logic [CNT_W-1:0]  skipped, stalls;
`endif

  rng_addr_gen #(.ADDR_W(ADDR_W), .LINE_LOG2(LINE_LOG2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base(cfg_base), .cfg_num_lines(cfg_num_lines), .cfg_count(cfg_count),
    .rng_ready(rng_ready), .rng_data(rng_data), .rng_next(rng_next),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .busy(busy), .done(done),
`ifdef RNG_ADDR_GEN_STATS_EN
    .skipped(skipped), .stalls(stalls),
`endif
    .issued(issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;
  int unsigned src_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // rng_mode/rdy_mode: 0 = always ready, 1 = random; rdy_mode 2 = hold req_ready low for 10 stalls.
  task automatic run_case(input logic [63:0] base, input int unsigned lines, input int unsigned count,
                          input int unsigned rng_mode, input int unsigned rdy_mode, input bit mid_start);
    logic [63:0] exp_q[$];
    logic [63:0] last_addr = '0;
    int unsigned n_acc = 0, n_iss = 0, n_skip = 0, n_stall = 0, hold_n = 0;
    int unsigned hs_first = 0, hs_last_cyc = 0, gaps = 0;
    int unsigned max_idx;
    bit stalled = 0, fin = 0, exp_pull;
    max_idx = (lines * 2 > 524287) ? 524287 : lines * 2;

    @(negedge clk);
    cfg_base = base; cfg_num_lines = 20'(lines); cfg_count = count;
    start = 1'b1; rng_ready = 1'b0; req_ready = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = mid_start && cyc == 4 && n_iss < count;
      cfg_base = {$urandom(), $urandom()};
      cfg_num_lines = 20'($urandom_range(0, 524288));
      cfg_count = $urandom();
      if (src_q.size() > 0) begin
        rng_ready = (rng_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        rng_data  = 19'(src_q[0]);
      end else begin
        rng_ready = (rng_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        rng_data  = 19'($urandom_range(0, max_idx));
        if (rng_mode == 0 && src_q.size() == 0 && lines < 524288) gaps++;
      end
      case (rdy_mode)
        0:       req_ready = 1'b1;
        1:       req_ready = ($urandom_range(0, 2) != 0);
        default: req_ready = !(req_valid && hold_n < 10);
      endcase
      #1;
      check("busy", busy, n_iss < count);
      check("done", done, n_iss >= count);
      check("issued", issued, n_iss);
      if (n_iss >= count) begin
        fin = 1;
        break;
      end
      check("valid", req_valid, n_acc > n_iss);
      if (stalled) check("hold", req_addr, last_addr);
      if (req_valid && exp_q.size() > 0) check("addr", req_addr, exp_q[0]);
      exp_pull = rng_ready && n_acc < count && (!req_valid || req_ready);
      check("pull", rng_next, exp_pull);
      if (req_valid && req_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (n_iss == 0) hs_first = cyc;
        hs_last_cyc = cyc;
        n_iss++;
      end
      if (rng_next && rng_ready) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        if (int'(rng_data) < int'(lines)) begin
          exp_q.push_back(base + 64'(rng_data) * (64'd1 << LINE_LOG2));
          n_acc++;
        end else begin
          n_skip++;
        end
      end
      stalled = req_valid && !req_ready;
      if (stalled) begin
        n_stall++;
        hold_n++;
      end
      last_addr = req_addr;
    end
    start = 1'b0;
    if (!fin) check("timeout", 0, 1);
    if (rng_mode == 0 && rdy_mode == 0 && n_skip == 0 && gaps == 0 && fin)
      check("b2b", hs_last_cyc - hs_first, count - 1);
`ifdef RNG_ADDR_GEN_STATS_EN
    check("skipped", skipped, n_skip);
    check("stalls", stalls, n_stall);
`endif
    src_q.delete();
  endtask

  task automatic zero_case(input int unsigned lines, input int unsigned count);
    @(negedge clk);
    cfg_base = 64'h4000; cfg_num_lines = 20'(lines); cfg_count = count;
    start = 1'b1; rng_ready = 1'b1; req_ready = 1'b1; rng_data = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_done1", done, 0);
    check("zero_next1", rng_next, 0);
    check("zero_valid1", req_valid, 0);
    @(negedge clk);
    #1;
    check("zero_done2", done, 1);
    check("zero_busy2", busy, 0);
    check("zero_next2", rng_next, 0);
    check("zero_valid2", req_valid, 0);
    check("zero_issued", issued, 0);
  endtask

  task automatic reset_case();
    @(negedge clk);
    cfg_base = 64'h2000; cfg_num_lines = 20'd524288; cfg_count = 50;
    start = 1'b1; rng_ready = 1'b0; req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; rng_ready = 1'b1; req_ready = 1'b1;
      rng_data = 19'($urandom_range(0, 524287));
    end
    req_ready = 1'b0;
    #1;
    check("rst_pre_valid", req_valid, 1);
    check("rst_pre_issued", issued != 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid", req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_issued", issued, 0);
    check("rst_addr", req_addr, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_base = '0; cfg_num_lines = '0; cfg_count = '0;
    rng_ready = 1'b1; rng_data = 19'd3; req_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("init_next", rng_next, 0);
    check("init_valid", req_valid, 0);
    check("init_addr", req_addr, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_issued", issued, 0);
    rst_n = 1'b1;

    src_q = '{5, 9, 2, 7};
    run_case(64'h1000, 524288, 4, 0, 0, 0);
    src_q = '{100, 3, 50, 6};
    run_case(64'h0, 8, 2, 0, 0, 0);
    src_q = '{0};
    run_case(64'h8000, 16, 1, 0, 2, 0);
    zero_case(100, 0);
    zero_case(0, 7);
    reset_case();
    src_q = '{1};
    run_case(64'hFFFF_FFFF_FFFF_FFC0, 524288, 1, 0, 0, 0);
    src_q = '{1, 2, 3};
    run_case(64'hFFFF_FFFF_FFFF_FFC0, 524288, 3, 1, 1, 1);
    for (int r = 0; r < 12; r++) begin
      int unsigned lines;
      case ($urandom_range(0, 2))
        0:       lines = $urandom_range(1, 16);
        1:       lines = 524288;
        default: lines = $urandom_range(1, 524288);
      endcase
      run_case({$urandom(), $urandom()}, lines, $urandom_range(1, 20), 1, 1, $urandom_range(0, 1) == 1);
    end
    zero_case(0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
